// File: rtl/ad5628_cmd_seq.sv
// AD5628 command sequencer: builds the power-up init frames and single-channel runtime
// update frames for the SPI serializer. Optional: AD5628_LDAC_SYNC_EN (input-register init + LDAC broadcast).
module ad5628_cmd_seq #(
    parameter int unsigned NUM_CH     = 8,
    parameter int unsigned GAP_CYCLES = 4,
    parameter int unsigned REF_ON     = 1
) (
    input  logic        clk_sys,
    input  logic        rst_sys_n,
    input  logic        start,
    input  logic        cfg_we,
    input  logic [2:0]  cfg_ch,
    input  logic [11:0] cfg_code,
    input  logic        upd_req,
    input  logic [2:0]  upd_ch,
    input  logic [11:0] upd_code,
    output logic        upd_ack,
    output logic [31:0] frame_data,
    output logic        frame_valid,
    input  logic        frame_ready,
    input  logic        frame_done,
    output logic        busy,
    output logic        done
);

`ifdef AD5628_LDAC_SYNC_EN
    localparam int unsigned LDAC_FRAMES = 1;
    localparam logic [3:0]  CMD_CH_INIT = 4'b0000;
`else
    localparam int unsigned LDAC_FRAMES = 0;
    localparam logic [3:0]  CMD_CH_INIT = 4'b0011;
`endif

    localparam int unsigned REF_ON_I  = (REF_ON != 0) ? 1 : 0;
    localparam int unsigned CH_BASE   = 1 + REF_ON_I;
    localparam int unsigned N_INIT    = CH_BASE + NUM_CH + LDAC_FRAMES;
    localparam int unsigned IW        = $clog2(NUM_CH + 3);
    localparam int unsigned GW        = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(N_INIT - 1);

    localparam logic [31:0] FRAME_RESET  = 32'h0700_0000;
    localparam logic [31:0] FRAME_REF_ON = 32'h0800_0001;
    localparam logic [31:0] FRAME_LDAC   = 32'h01F0_0000;
    localparam logic [3:0]  CMD_CH_RUN   = 4'b0011;
    localparam logic [11:0] CODE_RST     = 12'h800;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_WAIT_DONE,
        S_GAP,
        S_FIN
    } state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic            init_q, init_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;
    logic            valid_q, valid_d;
    logic            upd_ack_q, upd_ack_d;
    logic [2:0]      upd_ch_q, upd_ch_d;
    logic [11:0]     upd_code_q, upd_code_d;
    logic [31:0]     frame_data_q, frame_data_d;
    logic [11:0]     code_tbl_q [8];

    int unsigned     ch_off;
    logic [31:0]     init_word;
    logic [31:0]     run_word;
    logic            last_frame;
    logic            upd_wr;

    assign upd_ack     = upd_ack_q;
    assign frame_data  = frame_data_q;
    assign frame_valid = valid_q;
    assign busy        = busy_q;
    assign done        = done_q;

    // Frame word for the current init index; table value sampled here during LOAD
    always_comb begin
        ch_off    = 32'(idx_q) - CH_BASE;
        init_word = FRAME_RESET;
        if (REF_ON_I == 1 && idx_q == IW'(1)) begin
            init_word = FRAME_REF_ON;
        end else if (idx_q >= IW'(CH_BASE) && ch_off < NUM_CH) begin
            init_word = {4'h0, CMD_CH_INIT, 4'(ch_off), code_tbl_q[3'(ch_off)], 8'h00};
        end else if (LDAC_FRAMES == 1 && idx_q == LAST_IDX) begin
            init_word = FRAME_LDAC;
        end
        run_word = {4'h0, CMD_CH_RUN, 1'b0, upd_ch_q, upd_code_q, 8'h00};
    end

    // Next-state and output logic
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        gap_d        = gap_q;
        init_d       = init_q;
        done_d       = done_q;
        upd_ack_d    = 1'b0;
        upd_ch_d     = upd_ch_q;
        upd_code_d   = upd_code_q;
        frame_data_d = frame_data_q;
        upd_wr       = 1'b0;
        last_frame   = !init_q || (idx_q == LAST_IDX);

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    idx_d   = '0;
                    init_d  = 1'b1;
                    done_d  = 1'b0;
                end else if (upd_req) begin
                    upd_ack_d  = 1'b1;
                    upd_ch_d   = upd_ch;
                    upd_code_d = upd_code;
                    init_d     = 1'b0;
                    idx_d      = '0;
                    // Out-of-range channels are acknowledged but produce no frame
                    if (32'(upd_ch) < NUM_CH) begin
                        upd_wr  = 1'b1;
                        state_d = S_LOAD;
                    end else begin
                        state_d = S_FIN;
                    end
                end
            end
            S_LOAD: begin
                frame_data_d = init_q ? init_word : run_word;
                state_d      = S_SEND;
            end
            S_SEND: begin
                if (frame_ready) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (frame_done) begin
                    if (GAP_CYCLES == 0) begin
                        if (last_frame) begin
                            state_d = S_FIN;
                        end else begin
                            state_d = S_LOAD;
                            idx_d   = idx_q + IW'(1);
                        end
                    end else begin
                        state_d = S_GAP;
                        gap_d   = GW'(GAP_CYCLES);
                    end
                end
            end
            S_GAP: begin
                gap_d = gap_q - GW'(1);
                if (gap_q <= GW'(1)) begin
                    if (last_frame) begin
                        state_d = S_FIN;
                    end else begin
                        state_d = S_LOAD;
                        idx_d   = idx_q + IW'(1);
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
                if (init_q) begin
                    done_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        valid_d = (state_d == S_SEND);
        busy_d  = (state_d != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            gap_q        <= '0;
            init_q       <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            valid_q      <= 1'b0;
            upd_ack_q    <= 1'b0;
            upd_ch_q     <= '0;
            upd_code_q   <= '0;
            frame_data_q <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            gap_q        <= gap_d;
            init_q       <= init_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
            valid_q      <= valid_d;
            upd_ack_q    <= upd_ack_d;
            upd_ch_q     <= upd_ch_d;
            upd_code_q   <= upd_code_d;
            frame_data_q <= frame_data_d;
        end
    end

    // Channel code table; an accepted runtime update overrides a same-cycle cfg write
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            for (int i = 0; i < 8; i++) begin
                code_tbl_q[i] <= CODE_RST;
            end
        end else begin
            if (cfg_we && 32'(cfg_ch) < NUM_CH) begin
                code_tbl_q[cfg_ch] <= cfg_code;
            end
            if (upd_wr) begin
                code_tbl_q[upd_ch] <= upd_code;
            end
        end
    end

endmodule

// File: tb/tb_ad5628_cmd_seq.sv
// Self-checking bench for ad5628_cmd_seq: serializer model, table-driven updates,
// randomized init/update rounds against a frame-list reference model.
`timescale 1ns/1ps
module tb_ad5628_cmd_seq;

    localparam int unsigned NUM_CH     = 8;
    localparam int unsigned GAP_CYCLES = 4;
    localparam int unsigned REF_ON     = 1;
`ifdef AD5628_LDAC_SYNC_EN
    localparam bit LDAC = 1'b1;
`else
    localparam bit LDAC = 1'b0;
`endif
    localparam int CH_BASE = 1 + int'(REF_ON);
    localparam int N_INIT  = CH_BASE + int'(NUM_CH) + (LDAC ? 1 : 0);

    typedef struct packed {
        logic [2:0]  ch;
        logic [11:0] code;
        logic [31:0] exp_word;
    } upd_vec_t;

    logic        clk_sys = 1'b0;
    logic        rst_sys_n;
    logic        start;
    logic        cfg_we;
    logic [2:0]  cfg_ch;
    logic [11:0] cfg_code;
    logic        upd_req;
    logic [2:0]  upd_ch;
    logic [11:0] upd_code;
    logic        upd_ack;
    logic [31:0] frame_data;
    logic        frame_valid;
    logic        frame_ready = 1'b0;
    logic        frame_done  = 1'b0;
    logic        busy;
    logic        done;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    bit          ready_en = 1'b1;
    bit          inject_done = 1'b0;
    int          dly = 40;
    logic [31:0] got_q[$];
    logic [31:0] exp_q[$];
    logic [11:0] mtbl [8];
    int          min_idle = 1000000;
    int          n_gaps = 0;

    ad5628_cmd_seq #(.NUM_CH(NUM_CH), .GAP_CYCLES(GAP_CYCLES), .REF_ON(REF_ON)) dut (
        .clk_sys     (clk_sys),
        .rst_sys_n   (rst_sys_n),
        .start       (start),
        .cfg_we      (cfg_we),
        .cfg_ch      (cfg_ch),
        .cfg_code    (cfg_code),
        .upd_req     (upd_req),
        .upd_ch      (upd_ch),
        .upd_code    (upd_code),
        .upd_ack     (upd_ack),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .frame_done  (frame_done),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk_sys = ~clk_sys;

    // Serializer model: accepts a frame, stays busy for dly cycles, then pulses frame_done
    int  ser_cnt = 0;
    bit  pend = 1'b0;
    bit  prev_valid = 1'b0;
    int  last_done_cyc = -1;
    always @(negedge clk_sys) begin
        cyc++;
        frame_done  = inject_done;
        inject_done = 1'b0;
        if (!rst_sys_n) begin
            pend          = 1'b0;
            ser_cnt       = 0;
            frame_ready   = ready_en;
            prev_valid    = 1'b0;
            last_done_cyc = -1;
        end else begin
            if (frame_valid && !prev_valid && last_done_cyc >= 0) begin
                if (cyc - last_done_cyc - 1 < min_idle) min_idle = cyc - last_done_cyc - 1;
                n_gaps++;
                last_done_cyc = -1;
            end
            prev_valid = frame_valid;
            if (pend) begin
                pend        = 1'b0;
                frame_ready = 1'b0;
                ser_cnt     = dly;
            end else if (ser_cnt > 0) begin
                ser_cnt--;
                if (ser_cnt == 0) begin
                    frame_done    = 1'b1;
                    last_done_cyc = cyc;
                end
            end else begin
                frame_ready = ready_en;
            end
            if (frame_valid && frame_ready) begin
                got_q.push_back(frame_data);
                pend = 1'b1;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (busy && k < 5000) begin
            tick(1);
            k++;
        end
        if (busy) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: busy still %b expected 0", tag, busy);
        end
    endtask

    task automatic wait_frames(input int n, input string tag);
        int k = 0;
        while (got_q.size() < n && k < 3000) begin
            tick(1);
            k++;
        end
        if (got_q.size() < n) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_frames_timeout: got %0d frames expected %0d", tag, got_q.size(), n);
        end
    endtask

    // Reference: expected init frame list from the current table contents
    task automatic model_init();
        logic [31:0] w;
        exp_q.delete();
        exp_q.push_back(32'h0700_0000);
        if (REF_ON != 0) exp_q.push_back(32'h0800_0001);
        for (int c = 0; c < int'(NUM_CH); c++) begin
            w = 32'(LDAC ? 0 : 3) << 24;
            w = w | (32'(c) << 20) | (32'(mtbl[c]) << 8);
            exp_q.push_back(w);
        end
        if (LDAC) exp_q.push_back(32'h01F0_0000);
    endtask

    function automatic logic [31:0] upd_word(input logic [2:0] ch, input logic [11:0] code);
        return (32'd3 << 24) | (32'(ch) << 20) | (32'(code) << 8);
    endfunction

    task automatic compare_frames(input string tag);
        logic [31:0] g;
        check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < got_q.size()) ? got_q[i] : 32'hxxxx_xxxx;
            check($sformatf("%s_frame%0d", tag, i), g, exp_q[i]);
        end
    endtask

    task automatic run_init(input string tag);
        model_init();
        got_q.delete();
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_idle(tag);
        compare_frames(tag);
        check({tag, "_done"}, 32'(done), 32'd1);
    endtask

    task automatic cfg_write(input logic [2:0] ch, input logic [11:0] code);
        cfg_we   = 1'b1;
        cfg_ch   = ch;
        cfg_code = code;
        tick(1);
        cfg_we   = 1'b0;
        mtbl[ch] = code;
    endtask

    task automatic do_update(input logic [2:0] ch, input logic [11:0] code,
                             input logic [31:0] exp_word, input string tag);
        int k = 0;
        got_q.delete();
        upd_ch   = ch;
        upd_code = code;
        upd_req  = 1'b1;
        while (!upd_ack && k < 100) begin
            tick(1);
            k++;
        end
        check({tag, "_ack"}, 32'(upd_ack), 32'd1);
        upd_req = 1'b0;
        tick(1);
        check({tag, "_ack_pulse"}, 32'(upd_ack), 32'd0);
        wait_idle(tag);
        check({tag, "_count"}, 32'(got_q.size()), 32'd1);
        check({tag, "_word"}, (got_q.size() > 0) ? got_q[0] : 32'hxxxx_xxxx, exp_word);
        check({tag, "_done_kept"}, 32'(done), 32'd1);
        mtbl[ch] = code;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        upd_vec_t    vecs [5];
        logic [31:0] held;
        bit          stable;
        int          k;
        logic [2:0]  rch;
        logic [11:0] rcode;

        vecs[0] = '{ch: 3'd5, code: 12'h123, exp_word: 32'h0351_2300};
        vecs[1] = '{ch: 3'd0, code: 12'hFFF, exp_word: 32'h030F_FF00};
        vecs[2] = '{ch: 3'd7, code: 12'h001, exp_word: 32'h0370_0100};
        vecs[3] = '{ch: 3'd2, code: 12'hA5A, exp_word: 32'h032A_5A00};
        vecs[4] = '{ch: 3'd3, code: 12'h000, exp_word: 32'h0330_0000};

        rst_sys_n = 1'b0;
        start = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_code = '0;
        upd_req = 1'b0; upd_ch = '0; upd_code = '0;
        for (int i = 0; i < 8; i++) mtbl[i] = 12'h800;
        tick(3);
        check("rst_valid", 32'(frame_valid), 32'd0);
        check("rst_data", frame_data, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ack", 32'(upd_ack), 32'd0);
        rst_sys_n = 1'b1;
        tick(2);

        // Init with ch3 preloaded, latency check, and a start ignored while busy
        cfg_write(3'd3, 12'hABC);
        model_init();
        got_q.delete();
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("lat_c1_valid", 32'(frame_valid), 32'd0);
        check("lat_c1_busy", 32'(busy), 32'd1);
        tick(1);
        check("lat_c2_valid", 32'(frame_valid), 32'd1);
        check("lat_c2_data", frame_data, 32'h0700_0000);
        wait_frames(3, "busy_start");
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_idle("init1");
        compare_frames("init1");
        check("ch3_word", (got_q.size() > CH_BASE + 3) ? got_q[CH_BASE + 3] : 32'hxxxx_xxxx,
              LDAC ? 32'h003A_BC00 : 32'h033A_BC00);
        check("init1_done", 32'(done), 32'd1);
        check("init1_busy", 32'(busy), 32'd0);

        // Serializer stall on the ch1 frame, with a table write to ch1 while it is in flight
        model_init();
        got_q.delete();
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_frames(CH_BASE + 1, "stall");
        ready_en = 1'b0;
        k = 0;
        while (!frame_valid && k < 500) begin
            tick(1);
            k++;
        end
        held   = frame_data;
        stable = 1'b1;
        cfg_write(3'd1, 12'h5A5);
        for (int i = 0; i < 20; i++) begin
            if (!frame_valid || frame_data !== held) stable = 1'b0;
            tick(1);
        end
        check("stall_stable", 32'(stable), 32'd1);
        check("stall_no_accept", 32'(got_q.size()), 32'(CH_BASE + 1));
        check("stall_word_old_code", held, exp_q[CH_BASE + 1]);
        ready_en = 1'b1;
        wait_idle("init2");
        compare_frames("init2");

        // Table-driven runtime updates
        for (int v = 0; v < 5; v++) begin
            do_update(vecs[v].ch, vecs[v].code, vecs[v].exp_word, $sformatf("vec%0d", v));
        end

        // Stray frame_done while idle
        got_q.delete();
        inject_done = 1'b1;
        tick(3);
        check("stray_done_busy", 32'(busy), 32'd0);
        check("stray_done_frames", 32'(got_q.size()), 32'd0);

        // start and upd_req together: init first, update served after FIN
        model_init();
        exp_q.push_back(32'h0363_C300);
        got_q.delete();
        upd_ch = 3'd6; upd_code = 12'h3C3; upd_req = 1'b1;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        k = 0;
        while (!upd_ack && k < 5000) begin
            tick(1);
            k++;
        end
        check("both_ack_seen", 32'(upd_ack), 32'd1);
        check("both_ack_after_init", 32'(got_q.size()), 32'(N_INIT));
        check("both_done_at_ack", 32'(done), 32'd1);
        upd_req = 1'b0;
        mtbl[6] = 12'h3C3;
        tick(1);
        wait_idle("both");
        compare_frames("both");

        // Randomized rounds
        for (int it = 0; it < 4; it++) begin
            dly = $urandom_range(1, 40);
            for (int w = 0; w < 3; w++) begin
                rch   = 3'($urandom_range(0, 7));
                rcode = 12'($urandom);
                cfg_write(rch, rcode);
            end
            run_init($sformatf("rnd%0d_init", it));
            for (int u = 0; u < 2; u++) begin
                rch   = 3'($urandom_range(0, 7));
                rcode = 12'($urandom);
                do_update(rch, rcode, upd_word(rch, rcode), $sformatf("rnd%0d_upd%0d", it, u));
            end
        end
        dly = 40;

        // Reset in WAIT_DONE of frame 4, then a full replay
        got_q.delete();
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_frames(4, "mid_rst");
        tick(2);
        check("mid_wait_busy", 32'(busy), 32'd1);
        check("mid_wait_valid", 32'(frame_valid), 32'd0);
        #2;
        rst_sys_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(frame_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_data", frame_data, 32'd0);
        tick(2);
        rst_sys_n = 1'b1;
        for (int i = 0; i < 8; i++) mtbl[i] = 12'h800;
        tick(2);
        run_init("replay");
        check("replay_last", (got_q.size() > 0) ? got_q[got_q.size() - 1] : 32'hxxxx_xxxx,
              LDAC ? 32'h01F0_0000 : 32'h0378_0000);

        check("gaps_measured", 32'(n_gaps > 0), 32'd1);
        check("min_gap_ok", 32'(min_idle >= int'(GAP_CYCLES)), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
